// File: rtl/cpu_mul_combine.sv
// Multiplier combine stage: sums three 16x16 partial products into the low 32-bit result and
// queues results in a credit-managed FIFO. Define CPU_MUL_COMBINE_PIPE_EN for a 2-stage compute.
module cpu_mul_combine #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      push_result;
  logic [TAG_W-1:0] push_tag;
  logic [1:0]       occupancy;
  logic [4:0]       credits_used;

  logic [31:0]      result_q [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;

  // Upper halves of the cross products only affect bits above 31.
  logic unused_hi;
  assign unused_hi = ^{in_p2[31:16], in_p3[31:16]};

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign pop          = (count_q != 4'd0) && out_ready;
  // A pop this cycle frees its slot combinationally, so full-rate streaming never bubbles.
  assign credits_used = 5'(count_q) + 5'(occupancy) - 5'(pop);
  assign in_ready     = !flush && (credits_used < 5'(DEPTH));
  assign accept       = in_valid && in_ready;

`ifdef CPU_MUL_COMBINE_PIPE_EN
  logic             s1_valid_q;
  logic [31:0]      s1_p1_q;
  logic [15:0]      s1_mid_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [15:0]      mid;

  // Carry out of the 16-bit cross-product sum lands at bit 32 and is dropped.
  assign mid = in_p2[15:0] + in_p3[15:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_p1_q    <= '0;
      s1_mid_q   <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_p1_q  <= in_p1;
        s1_mid_q <= mid;
        s1_tag_q <= in_tag;
      end
    end
  end

  assign push        = s1_valid_q;
  assign push_result = s1_p1_q + {s1_mid_q, 16'h0000};
  assign push_tag    = s1_tag_q;
  assign occupancy   = {1'b0, s1_valid_q};
`else
  assign push        = accept;
  assign push_result = in_p1 + {in_p2[15:0], 16'h0000} + {in_p3[15:0], 16'h0000};
  assign push_tag    = in_tag;
  assign occupancy   = 2'b00;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + {3'b000, push} - {3'b000, pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        result_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else if (push && !flush) begin
      result_q[wr_ptr_q] <= push_result;
      tag_q[wr_ptr_q]    <= push_tag;
    end
  end

  assign out_valid  = (count_q != 4'd0);
  assign out_result = result_q[rd_ptr_q];
  assign out_tag    = tag_q[rd_ptr_q];
  assign out_count  = count_q;

endmodule

// File: tb/tb_cpu_mul_combine.sv
// Directed bench for cpu_mul_combine: table of hand-computed products plus backpressure,
// full-rate wrap, flush and asynchronous-reset sequences.
module tb_cpu_mul_combine;

`ifdef CPU_MUL_COMBINE_PIPE_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam int unsigned Depth = 2;
  localparam int unsigned TagW  = 5;

  logic            clk;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [TagW-1:0] in_tag;
  logic [31:0]     in_p1;
  logic [31:0]     in_p2;
  logic [31:0]     in_p3;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_result;
  logic [TagW-1:0] out_tag;
  logic [3:0]      out_count;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [31:0]     p1;
    logic [31:0]     p2;
    logic [31:0]     p3;
    logic [TagW-1:0] tag;
    logic [31:0]     exp;
  } vec_t;

  vec_t vecs [7];

  cpu_mul_combine #(
    .DEPTH (Depth),
    .TAG_W (TagW)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .in_p1      (in_p1),
    .in_p2      (in_p2),
    .in_p3      (in_p3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    int n;
    in_valid  = 1'b1;
    in_p1     = v.p1;
    in_p2     = v.p2;
    in_p3     = v.p3;
    in_tag    = v.tag;
    out_ready = 1'b1;
    #1;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      next_cycle();
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(Lat));
    check({name, " result"}, out_result, v.exp);
    check({name, " tag"}, 32'(out_tag), 32'(v.tag));
    next_cycle();
    check({name, " drained"}, 32'(out_count), 32'd0);
  endtask

  // Offer products with out_ready low until `num` are accepted (bounded).
  task automatic fill(input int num, input int first_tag);
    int acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && acc < num; c++) begin
      in_valid = 1'b1;
      in_tag   = TagW'(first_tag + acc);
      in_p1    = 32'(first_tag + acc);
      in_p2    = '0;
      in_p3    = '0;
      #1;
      if (in_ready) acc++;
      next_cycle();
    end
    in_valid = 1'b0;
    check("fill accepted", 32'(acc), 32'(num));
  endtask

  task automatic wait_count(input logic [3:0] target);
    for (int c = 0; c < 6 && out_count != target; c++) next_cycle();
  endtask

  initial begin
    int next_tag;
    int got;
    logic acc;

    vecs[0] = '{32'h0000_0008, 32'h0000_000A, 32'h0000_000C, 5'd3,  32'h0016_0008};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd1,  32'h0000_FFFF};
    vecs[2] = '{32'h0000_0000, 32'h0001_FFFF, 32'h0000_0001, 5'd2,  32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 32'hDEAD_0001, 32'hBEEF_0002, 5'd31, 32'h1237_5678};
    vecs[4] = '{32'h0000_ABCD, 32'h0000_8000, 32'h0000_8000, 5'd7,  32'h0000_ABCD};
    vecs[5] = '{32'hFFFF_0000, 32'h0000_0001, 32'h0000_0002, 5'd16, 32'h0002_0000};
    vecs[6] = '{32'h0000_0001, 32'h0000_FFFF, 32'h0000_FFFF, 5'd9,  32'hFFFE_0001};

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_tag    = '0;
    in_p1     = '0;
    in_p2     = '0;
    in_p3     = '0;
    out_ready = 1'b0;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    check("reset out_count", 32'(out_count), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: four products into a two-entry buffer, then release.
    next_tag = 1;
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      in_valid  = (next_tag <= 4);
      in_tag    = TagW'(next_tag);
      in_p1     = 32'(next_tag);
      in_p2     = '0;
      in_p3     = '0;
      out_ready = (c >= 6);
      #1;
      if (c == 5) begin
        check("bp out_count", 32'(out_count), 32'd2);
        check("bp in_ready", 32'(in_ready), 32'd0);
        check("bp accepted", 32'(next_tag - 1), 32'd2);
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp tag%0d", got + 1), 32'(out_tag), 32'(got + 1));
        check($sformatf("bp result%0d", got + 1), out_result, 32'(got + 1));
        got++;
      end
      acc = in_valid && in_ready;
      next_cycle();
      if (acc) next_tag++;
    end
    in_valid = 1'b0;
    check("bp popped", 32'(got), 32'd4);
    check("bp empty", 32'(out_count), 32'd0);
    check("bp out_valid", 32'(out_valid), 32'd0);

    // Full buffer with simultaneous push and pop for ten products.
    fill(2, 20);
    wait_count(4'd2);
    check("full count", 32'(out_count), 32'd2);
    for (int c = 0; c < 10; c++) begin
      in_valid  = 1'b1;
      in_tag    = TagW'(22 + c);
      in_p1     = 32'(22 + c);
      out_ready = 1'b1;
      #1;
      check($sformatf("stream%0d in_ready", c), 32'(in_ready), 32'd1);
      check($sformatf("stream%0d tag", c), 32'(out_tag), 32'(20 + c));
      check($sformatf("stream%0d result", c), out_result, 32'(20 + c));
      check($sformatf("stream%0d count", c), 32'(out_count),
            (Lat == 1 || c == 0) ? 32'd2 : 32'd1);
      next_cycle();
    end
    in_valid = 1'b0;
    wait_count(4'd0);
    check("stream drained", 32'(out_count), 32'd0);

    // Flush with a full buffer while a push and pop are both offered.
    fill(2, 5);
    wait_count(4'd2);
    check("pre-flush count", 32'(out_count), 32'd2);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 5'd8;
    in_p1     = 32'd8;
    out_ready = 1'b1;
    #1;
    check("flush in_ready", 32'(in_ready), 32'd0);
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post-flush out_count", 32'(out_count), 32'd0);
    check("post-flush in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("post-flush out_valid%0d", c), 32'(out_valid), 32'd0);
      next_cycle();
    end

    // Asynchronous reset between clock edges with a result buffered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_p1     = vecs[3].p1;
    in_p2     = vecs[3].p2;
    in_p3     = vecs[3].p3;
    in_tag    = vecs[3].tag;
    next_cycle();
    in_valid = 1'b0;
    wait_count(4'd1);
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset out_result", out_result, 32'd0);
    check("async reset out_count", 32'(out_count), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    apply_vec(vecs[0], "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
